// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Purpose  : Posted-write buffer between the CPU data-memory port and the
//            data RAM. Stores retire into a FIFO in one cycle and drain to
//            the RAM whenever its single port is not taken by a load. Loads
//            pass straight through unless they hit a pending store.
// Ports    : clk, rst (synchronous, active-low)
//            cpu_ce_i/cpu_we_i/cpu_addr_i/cpu_sel_i/cpu_data_i : CPU request
//            cpu_data_o : load data, stall_o : CPU must repeat the request
//            ram_ce_o/ram_we_o/ram_addr_o/ram_sel_o/ram_data_o : RAM port
//            ram_data_i : RAM read data (combinational read)
//            empty_o    : no pending stores
// Options  : STORE_BUFFER_FWD_EN - forward buffered bytes to hitting loads
//            instead of stalling until the matching entry has drained.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stall_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        empty_o
);

    localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

    logic [29:0]      r_addr [DEPTH];
    logic [3:0]       r_sel  [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic [DEPTH-1:0] w_match;
    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_drain;
    logic             w_read;
    logic [31:0]      w_load_data;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign empty_o = w_empty;

    // Word-granular hit detection; byte enables do not matter for a hit.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = r_valid[i] && (r_addr[i] == cpu_addr_i[31:2]);
        end
    end

    // Single-port arbitration. Everything is forced idle while in reset so a
    // reset arriving mid-drain never lets a discarded entry reach the RAM.
    always_comb begin
        w_enq   = 1'b0;
        w_drain = 1'b0;
        w_read  = 1'b0;
        stall_o = 1'b0;
        if (rst) begin
            if (cpu_ce_i && !cpu_we_i) begin
`ifdef STORE_BUFFER_FWD_EN
                w_read = 1'b1;
`else
                if (|w_match) begin
                    // Hold the load and push the buffer towards the hit.
                    stall_o = 1'b1;
                    w_drain = 1'b1;
                end else begin
                    w_read = 1'b1;
                end
`endif
            end else if (cpu_ce_i && cpu_we_i) begin
                if (w_full) begin
                    stall_o = 1'b1;
                    w_drain = 1'b1;
                end else begin
                    w_enq   = 1'b1;
                    w_drain = !w_empty;
                end
            end else begin
                w_drain = !w_empty;
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    // Walk oldest to youngest so the youngest matching lane wins.
    always_comb begin
        logic [PTR_W-1:0] w_idx;
        w_load_data = ram_data_i;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + PTR_W'(i);
            if (w_match[w_idx]) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_sel[w_idx][b]) begin
                        w_load_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
                    end
                end
            end
        end
    end
`else
    assign w_load_data = ram_data_i;
`endif

    // RAM port and load-data muxing; a read and a drain are never both set.
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_sel_o  = '0;
        ram_data_o = '0;
        cpu_data_o = '0;
        if (w_read) begin
            ram_ce_o   = 1'b1;
            ram_addr_o = cpu_addr_i;
            ram_sel_o  = cpu_sel_i;
            cpu_data_o = w_load_data;
        end else if (w_drain) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = {r_addr[r_rd_ptr], 2'b00};
            ram_sel_o  = r_sel[r_rd_ptr];
            ram_data_o = r_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Enqueue never targets the drained slot: enqueue needs !full and
            // drain needs !empty, so wr_ptr != rd_ptr when both happen.
            if (w_enq) begin
                r_addr[r_wr_ptr]  <= cpu_addr_i[31:2];
                r_sel[r_wr_ptr]   <= cpu_sel_i;
                r_data[r_wr_ptr]  <= cpu_data_i;
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_drain) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + (PTR_W + 1)'(w_enq) - (PTR_W + 1)'(w_drain);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none

module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_ce = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [3:0]  cpu_sel = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        ram_ce;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_ce_i(cpu_ce), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
        .cpu_sel_i(cpu_sel), .cpu_data_i(cpu_wdata), .cpu_data_o(cpu_rdata),
        .stall_o(stall),
        .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_sel_o(ram_sel), .ram_data_o(ram_wdata), .ram_data_i(ram_rdata),
        .empty_o(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int idx);
        if (idx == (32'h300 >> 2)) return 32'hAABBCCDD;
        return 32'h5A5A0000 | 32'(idx);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Data RAM with combinational read.
    logic [31:0] mem [1024];
    bit          mem_loaded = 1'b0;
    assign ram_rdata = mem[ram_addr[11:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_writes[$];
    logic [31:0] exp_loads[$];
    logic [29:0] pending[$];
    logic [31:0] arch_mem[int];    // program-order memory seen by the CPU
    logic [31:0] commit_mem[int];  // what has legitimately reached RAM
    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_stall = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_commit(input int idx);
        return commit_mem.exists(idx) ? commit_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [31:0] rd_arch(input int idx);
        return arch_mem.exists(idx) ? arch_mem[idx] : init_word(idx);
    endfunction

    // Monitor: samples on the falling edge, pops expectations as the DUT
    // presents writes and completed loads.
    always @(negedge clk) begin
        bit  is_load, is_store, hit, exp_stall, exp_drain;
        wr_t w;
        int  idx;
        if (!rst) begin
            check("rst_stall", 32'(stall), 0);
            check("rst_ram_ce", 32'(ram_ce), 0);
            check("rst_ram_we", 32'(ram_we), 0);
            check("rst_cpu_data", cpu_rdata, 0);
            check("rst_ram_addr", ram_addr, 0);
            pending.delete();
            exp_writes.delete();
            mon_stall = 1'b0;
        end else begin
            is_load  = cpu_ce && !cpu_we;
            is_store = cpu_ce && cpu_we;
            hit = 1'b0;
            foreach (pending[i]) if (pending[i] == cpu_addr[31:2]) hit = 1'b1;
            exp_stall = (is_store && pending.size() == DEPTH) || (is_load && hit && !FWD);
            exp_drain = (pending.size() != 0) && !(is_load && !exp_stall);
            check("stall", 32'(stall), 32'(exp_stall));
            check("empty", 32'(empty), 32'(pending.size() == 0));
            check("ram_we", 32'(ram_we), 32'(exp_drain));
            check("ram_ce", 32'(ram_ce), 32'(exp_drain || (is_load && !exp_stall)));
            mon_stall = stall;
            if (ram_ce && ram_we) begin
                if (exp_writes.size() == 0) begin
                    check("unexpected_write", ram_addr, 32'hFFFF_FFFF);
                end else begin
                    w = exp_writes.pop_front();
                    check("wr_addr", ram_addr, {w.addr[31:2], 2'b00});
                    check("wr_sel", 32'(ram_sel), 32'(w.sel));
                    check("wr_data", ram_wdata, w.data);
                    idx = int'(w.addr[11:2]);
                    commit_mem[idx] = merge(rd_commit(idx), w.data, w.sel);
                end
                if (pending.size() > 0) void'(pending.pop_front());
            end else begin
                check("ram_data_idle", ram_wdata, 0);
            end
            if (is_load && !stall) begin
                check("rd_addr", ram_addr, cpu_addr);
                check("rd_sel", 32'(ram_sel), 32'(cpu_sel));
                if (exp_loads.size() == 0) check("unexpected_load", cpu_rdata, 32'hFFFF_FFFF);
                else check("load_data", cpu_rdata, exp_loads.pop_front());
            end
            if (stall) check("stall_data", cpu_rdata, 0);
            if (is_store && !stall) pending.push_back(cpu_addr[31:2]);
        end
    end

    // Issue one request and hold it until the DUT accepts it.
    task automatic do_op(input bit ce, input bit we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] data);
        bit done;
        int idx;
        cpu_ce = ce; cpu_we = we; cpu_addr = addr; cpu_sel = sel; cpu_wdata = data;
        idx = int'(addr[11:2]);
        if (ce && we) begin
            exp_writes.push_back('{addr, sel, data});
            arch_mem[idx] = merge(rd_arch(idx), data, sel);
        end else if (ce) begin
            exp_loads.push_back(rd_arch(idx));
        end
        done = 1'b0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            if (!mon_stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("stall_timeout", 32'(1), 32'(0));
        #1;
        cpu_ce = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_op(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic pulse_reset();
        cpu_ce = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        arch_mem = commit_mem;
        exp_loads.delete();
    endtask

    initial begin
        int r;
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // Four sequential stores, then idle until drained.
        do_op(1, 1, 32'h100, 4'hF, 32'h11);
        do_op(1, 1, 32'h104, 4'hF, 32'h22);
        do_op(1, 1, 32'h108, 4'hF, 32'h33);
        do_op(1, 1, 32'h10C, 4'hF, 32'h44);
        idle(4);

        // Non-hitting load passes through with an entry pending.
        do_op(1, 1, 32'h100, 4'hF, 32'h55);
        do_op(1, 0, 32'h200, 4'hF, 32'h0);
        idle(2);

        // Load hitting a buffered store.
        do_op(1, 1, 32'h104, 4'hF, 32'hDEADBEEF);
        do_op(1, 0, 32'h104, 4'hF, 32'h0);
        idle(2);

        // Partial stores to one word, then load of the merged word.
        do_op(1, 1, 32'h300, 4'b0001, 32'h11);
        do_op(1, 1, 32'h300, 4'b0010, 32'h2200);
        do_op(1, 0, 32'h300, 4'hF, 32'h0);
        idle(2);

        // Reset with a store pending: it must never reach RAM.
        do_op(1, 1, 32'h108, 4'hF, 32'h77);
        do_op(1, 1, 32'h10C, 4'hF, 32'h88);
        pulse_reset();
        do_op(1, 0, 32'h10C, 4'hF, 32'h0);
        idle(2);

        // Randomized traffic over a few words so hits are frequent.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            r = $urandom_range(0, 9);
            a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            if (r < 4)      do_op(1, 1, a, 4'($urandom_range(0, 15)), $urandom);
            else if (r < 8) do_op(1, 0, a, 4'($urandom_range(0, 15)), 32'h0);
            else            idle(1);
        end
        idle(4);
        check("writes_left", 32'(exp_writes.size()), 0);
        check("loads_left", 32'(exp_loads.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the GenshinMIPS data-memory port (ram_* signals) and data_ram in the minimal SOPC.
- Stores retire into a FIFO in one cycle. The FIFO drains to data_ram whenever the RAM port is free.
- Loads pass straight through to data_ram. A load stalls the CPU only when it hits a pending buffered store, or when the buffer is full and a store arrives.

Parameters:
- DEPTH, 4, number of buffer entries; power of 2, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low: rst==0 at a posedge resets.
- cpu_ce_i  in  1  CPU data access valid.
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address.
- cpu_sel_i  in  4  byte enables; bit3 = bits[31:24].
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data to CPU.
- stall_o  out  1  CPU must hold the request and repeat it next cycle.
- ram_ce_o  out  1  RAM enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  RAM address.
- ram_sel_o  out  4  RAM byte enables.
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data; combinational read.
- empty_o  out  1  buffer holds no pending stores.

Behaviour:
- Storage:
  - DEPTH entries of {addr[31:2], sel, data} with valid bits.
  - wr_ptr/rd_ptr of PTR_W bits, wrap modulo DEPTH.
  - count of PTR_W+1 bits.
  - full = (count==DEPTH); empty_o = (count==0).
- Hit: some valid entry has addr[31:2] == cpu_addr_i[31:2]; sel is ignored for hit detection.
- Per-cycle arbitration of the single RAM port; outputs are combinational from current state and inputs:
  - Reset, rst==0: stall_o=0, ram_ce_o=0, ram_we_o=0, cpu_data_o=0, all other ram_* outputs 0. Next state: count=0, pointers=0, all entries invalid. Pending writes are discarded, including after a reset mid-drain.
  - Load (ce=1, we=0), no hit:
    - ram_ce_o=1, ram_we_o=0, ram_addr_o=cpu_addr_i, ram_sel_o=cpu_sel_i; cpu_data_o=ram_data_i; stall_o=0.
    - No drain this cycle.
  - Load with hit: stall_o=1; drain head; cpu_data_o=0.
  - Store (ce=1, we=1), not full:
    - Enqueue at wr_ptr; stall_o=0.
    - If the buffer was non-empty, drain head the same cycle.
    - count updates by +1-1 = 0 when both happen, else +1.
  - Store when full: stall_o=1; drain head; no enqueue.
  - Idle (ce=0): drain head if non-empty; otherwise ram_ce_o=0.
- Drain head:
  - ram_ce_o=1, ram_we_o=1, ram_addr_o={entry.addr,2'b00}, ram_sel_o=entry.sel, ram_data_o=entry.data.
  - At posedge: rd_ptr+1, count-1, entry invalidated.
- Ordering:
  - Writes reach RAM in program order.
  - Two stores to the same word are both buffered; no merging.
- When not driving a write, ram_we_o=0 and ram_data_o=0.
- Latency:
  - Store visible in RAM no earlier than 1 cycle after enqueue.
  - A hitting load completes at most count cycles after first assertion.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: a load hit does not stall.
  - cpu_data_o starts as ram_data_i from a normal pass-through read (ram_ce_o=1, ram_we_o=0).
  - For each byte lane, the value is then overwritten by the youngest valid matching entry whose sel bit for that lane is set.
  - stall_o=0; no drain that cycle.
- Not defined: hit-stall behaviour as specified above.

Test Plan:
- Reset: rst=0 for 2 cycles with stores pending → count=0, empty_o=1, stall_o=0, ram_ce_o=0; RAM is not written by the discarded entries.
- Four stores 0x11,0x22,0x33,0x44 to 0x100/0x104/0x108/0x10C (sel=4'hF) on consecutive cycles, then idle → no stall; RAM written in order 0x100..0x10C; empty_o=1 after 4 idle-or-store drain cycles.
- Fill: a fifth store while count==4 with CPU holding the request → stall_o=1 for exactly 1 cycle, head drained, store accepted next cycle.
- Load 0x200 with buffer holding 0x100 only → ram_addr_o=0x200, stall_o=0, cpu_data_o=RAM value, count unchanged.
- Load 0x104 after store 0xDEADBEEF to 0x104 is buffered at position 2 → stall_o high until the entry drains, then cpu_data_o=0xDEADBEEF. With STORE_BUFFER_FWD_EN defined: returns 0xDEADBEEF with no stall.
- FWD only: RAM[0x300]=0xAABBCCDD; stores 0x11 (sel=0001), then 0x2200 (sel=0010), both to 0x300 → load 0x300 returns 0xAABB2211 with no stall.
